// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
package result_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int   BITS_PER_BYTE   = 8;
  localparam int   BYTES_PER_FRAME = 2;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

endpackage

// File: rtl/result_uart_tx_timer.sv
// Bit-period timer: strobes bit_end on the last cycle of each CLKS_PER_BIT window.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  // Wrapping on bit_end makes every bit boundary a fresh restart.
  always_ff @(posedge i_clock) begin
    if (i_reset || restart || bit_end) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Sends a signed result plus carry as two 8N1 bytes: low byte, then {carry, sign-extended high bits}.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int SIZE_OPERANDOS = 9,
  parameter int CLKS_PER_BIT   = 10416
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [SIZE_OPERANDOS-1:0] i_res,
  input  logic                      i_carry,
  input  logic                      i_send,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);

  tx_state_e state, state_nxt;
  logic       byte_idx, byte_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic       load;
  logic       tx_nxt, done_nxt;
  logic       bit_end;

  logic signed [SIZE_OPERANDOS-1:0] shadow_res;
  logic                             shadow_carry;
  logic signed [14:0]               res_ext;
  logic [7:0]                       byte0, byte1, tx_byte;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .restart (state == ST_IDLE),
    .bit_end (bit_end)
  );

  // byte1[6:0]:byte0 forms a 15-bit two's-complement copy of the result.
  assign res_ext = 15'(shadow_res);
  assign byte0   = res_ext[7:0];
  assign byte1   = {shadow_carry, res_ext[14:8]};
  assign tx_byte = byte_nxt ? byte1 : byte0;

  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_idx;
    bit_nxt   = bit_idx;
    load      = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: if (i_send) begin
        load      = 1'b1;
        byte_nxt  = 1'b0;
        bit_nxt   = '0;
        state_nxt = ST_START;
      end
      ST_START: if (bit_end) begin
        bit_nxt   = '0;
        state_nxt = ST_DATA;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx == 3'(BITS_PER_BYTE - 1)) state_nxt = ST_STOP;
        else                                  bit_nxt   = bit_idx + 3'd1;
      end
      ST_STOP: if (bit_end) begin
        if (byte_idx == 1'(BYTES_PER_FRAME - 1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          byte_nxt  = byte_idx + 1'b1;
          state_nxt = ST_START;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Line level is computed for the upcoming state so o_tx can be a plain flop.
    unique case (state_nxt)
      ST_START: tx_nxt = START_LEVEL;
      ST_DATA:  tx_nxt = tx_byte[bit_nxt];
      default:  tx_nxt = STOP_LEVEL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      byte_idx     <= 1'b0;
      bit_idx      <= '0;
      shadow_res   <= '0;
      shadow_carry <= 1'b0;
      o_tx         <= STOP_LEVEL;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_nxt;
      bit_idx  <= bit_nxt;
      if (load) begin
        shadow_res   <= i_res;
        shadow_carry <= i_carry;
      end
      o_tx   <= tx_nxt;
      o_busy <= (state_nxt != ST_IDLE);
      o_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx with a 4-cycle bit period.
module tb_result_uart_tx;

  localparam int SZ  = 9;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          i_reset, i_carry, i_send;
  logic [SZ-1:0] i_res;
  logic          o_tx, o_busy, o_done;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  result_uart_tx #(.SIZE_OPERANDOS(SZ), .CLKS_PER_BIT(CPB)) dut (
    .i_clock (clk),
    .i_reset (i_reset),
    .i_res   (i_res),
    .i_carry (i_carry),
    .i_send  (i_send),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // Reference: {byte1, byte0}, sign extension done with integer arithmetic.
  function automatic logic [15:0] model(input logic [SZ-1:0] r, input logic c);
    int v;
    logic [14:0] w;
    v = r[SZ-1] ? int'(r) - (1 << SZ) : int'(r);
    w = v[14:0];
    return {c, w[14:8], w[7:0]};
  endfunction

  task automatic send_req(input logic [SZ-1:0] r, input logic c);
    @(negedge clk);
    i_res = r; i_carry = c; i_send = 1'b1;
    exp_q.push_back(model(r, c));
    @(negedge clk);
    i_send = 1'b0;
  endtask

  // Samples one two-byte frame mid-bit; returns at the negedge where o_done should be high.
  task automatic rx_frame(output logic [15:0] word, output bit frame_ok,
                          output bit done_ok, output bit timed_out);
    int m, t, j, p;
    t = 0;
    while (o_tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    timed_out = (o_tx !== 1'b0);
    frame_ok = 1'b1; done_ok = 1'b1; word = '0;
    if (timed_out) return;
    m = 0;
    for (int k = 0; k < 20; k++) begin
      while (m < k*CPB + CPB/2) begin @(negedge clk); m++; end
      j = k / 10; p = k % 10;
      if (o_busy !== 1'b1) frame_ok = 1'b0;
      if (p == 0) begin
        if (o_tx !== 1'b0) frame_ok = 1'b0;
      end else if (p == 9) begin
        if (o_tx !== 1'b1) frame_ok = 1'b0;
      end else begin
        word[j*8 + p - 1] = o_tx;
      end
    end
    while (m < 20*CPB - 1) begin @(negedge clk); m++; end
    if (o_done !== 1'b0 || o_busy !== 1'b1) done_ok = 1'b0;
    @(negedge clk);
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1) done_ok = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_send = 1'b0; i_res = '0; i_carry = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_tx === 1'b1) passed++; else $display("FAIL reset_tx got %b expected 1", o_tx);
    total++; if (o_busy === 1'b0) passed++; else $display("FAIL reset_busy got %b expected 0", o_busy);
    total++; if (o_done === 1'b0) passed++; else $display("FAIL reset_done got %b expected 0", o_done);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_values;
    logic [SZ-1:0] rs[3] = '{9'h005, 9'h1FD, 9'h100};
    logic          cs[3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] word, exp;
    bit fok, dok, to;
    int d0;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      send_req(rs[i], cs[i]);
      rx_frame(word, fok, dok, to);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++; if (!to) passed++; else $display("FAIL values%0d_start no start bit seen", i);
      total++; if (word === exp) passed++; else $display("FAIL values%0d_data got %h expected %h", i, word, exp);
      total++; if (fok) passed++; else $display("FAIL values%0d_framing start/stop/busy wrong, expected 0/1/1", i);
      total++; if (dok) passed++; else $display("FAIL values%0d_done_timing done/busy edge not at cycle %0d", i, 20*CPB);
      total++; if (done_cnt - d0 == 1) passed++; else $display("FAIL values%0d_done_count got %0d expected 1", i, done_cnt - d0);
    end
  endtask

  task automatic test_mid_frame;
    logic [15:0] word, exp;
    bit fok, dok, to;
    int d0;
    d0 = done_cnt;
    send_req(9'h0A5, 1'b1);
    fork
      rx_frame(word, fok, dok, to);
      begin
        repeat (30) @(negedge clk);
        i_res = 9'h033; i_carry = 1'b0; i_send = 1'b1;
        @(negedge clk); i_send = 1'b0;
        repeat (30) @(negedge clk);
        i_res = 9'h1AA; i_send = 1'b1;
        @(negedge clk); i_send = 1'b0;
      end
    join
    repeat (2*CPB) @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (word === exp) passed++; else $display("FAIL mid_frame_data got %h expected %h", word, exp);
    total++; if (fok && dok && !to) passed++; else $display("FAIL mid_frame_timing framing=%b done=%b expected 1/1", fok, dok);
    total++; if (done_cnt - d0 == 1) passed++; else $display("FAIL mid_frame_done_count got %0d expected 1", done_cnt - d0);
    total++; if (o_busy === 1'b0) passed++; else $display("FAIL mid_frame_restart busy got %b expected 0", o_busy);
  endtask

  task automatic test_reset_mid;
    logic [15:0] word, exp;
    bit fok, dok, to;
    int d0;
    d0 = done_cnt;
    send_req(9'h0C3, 1'b0);
    repeat (13*CPB) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    total++; if (o_tx === 1'b1 && o_busy === 1'b0 && o_done === 1'b0) passed++;
    else $display("FAIL reset_mid_outputs got tx=%b busy=%b done=%b expected 1/0/0", o_tx, o_busy, o_done);
    i_reset = 1'b0;
    void'(exp_q.pop_front());
    repeat (3*CPB) @(negedge clk);
    total++; if (done_cnt == d0 && o_tx === 1'b1) passed++;
    else $display("FAIL reset_mid_abandon done pulses %0d tx %b expected 0 and 1", done_cnt - d0, o_tx);
    send_req(9'h1C3, 1'b1);
    rx_frame(word, fok, dok, to);
    exp = exp_q.pop_front();
    total++; if (word === exp) passed++; else $display("FAIL reset_mid_refire_data got %h expected %h", word, exp);
    total++; if (fok && dok && !to) passed++; else $display("FAIL reset_mid_refire_timing framing=%b done=%b expected 1/1", fok, dok);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send_reset;
    @(negedge clk);
    i_res = 9'h0FF; i_send = 1'b1; i_reset = 1'b1;
    @(negedge clk);
    i_send = 1'b0; i_reset = 1'b0;
    total++; if (o_tx === 1'b1 && o_busy === 1'b0) passed++;
    else $display("FAIL send_reset_edge got tx=%b busy=%b expected 1/0", o_tx, o_busy);
    repeat (3*CPB) @(negedge clk);
    total++; if (o_tx === 1'b1 && o_busy === 1'b0) passed++;
    else $display("FAIL send_reset_idle got tx=%b busy=%b expected 1/0", o_tx, o_busy);
  endtask

  task automatic test_done_coincident;
    logic [15:0] word, exp;
    bit fok, dok, to;
    send_req(9'h07E, 1'b0);
    fork
      rx_frame(word, fok, dok, to);
      begin
        repeat (20*CPB - 1) @(negedge clk);
        i_send = 1'b1;
        @(negedge clk); i_send = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    total++; if (word === exp && dok) passed++; else $display("FAIL coincide_frame got %h done=%b expected %h done=1", word, dok, exp);
    repeat (2) @(negedge clk);
    total++; if (o_busy === 1'b0 && o_tx === 1'b1) passed++;
    else $display("FAIL coincide_ignored got busy=%b tx=%b expected 0/1", o_busy, o_tx);
  endtask

  initial begin
    test_reset();
    test_values();
    test_mid_frame();
    test_reset_mid();
    test_send_reset();
    test_done_coincident();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
